// File: rtl/debugger_mem_cmd_pkg.sv
// Shared debugger definitions: opcodes, access direction and the command FSM
// state encoding. The memory arbiter imports the same package so both sides
// agree on what o_debugger_rw means.
package debugger_mem_cmd_pkg;

    localparam logic [7:0] OP_READ  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [3:0] {
        IDLE,
        ADDR_LO,
        ADDR_HI,
        COUNT,
        WR_DATA,
        WR_MEM,
        RD_MEM,
        RD_WAIT,
        RD_SEND,
        RESP
    } dbg_state_e;

    // A count byte of zero encodes a full 256-byte transfer.
    function automatic logic [8:0] count_load(input logic [7:0] b);
        return (b == 8'h00) ? 9'd256 : {1'b0, b};
    endfunction

endpackage

// File: rtl/debugger_mem_cmd.sv
// Debugger memory command engine: parses opcode/addr/count byte commands from
// the rx stream, issues single-cycle accesses on the arbiter's debugger port
// and returns read data, an ack, or an error byte on the tx stream.
module debugger_mem_cmd
    import debugger_mem_cmd_pkg::*;
#(
    parameter logic [7:0] ACK_BYTE = 8'hAA,
    parameter logic [7:0] ERR_BYTE = 8'hEE
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_ready,
    output logic        o_debugger_en,
    output logic        o_debugger_rw,
    output logic [15:0] o_debugger_address,
    output logic [7:0]  o_debugger_data,
    input  logic [7:0]  i_debugger_data,
    output logic        o_busy,
    output logic        o_rx_overrun
);

    dbg_state_e  state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [8:0]  count_q, count_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  txd_q, txd_d;
    logic        is_rd_q, is_rd_d;
    logic        rx_accept;

    // Only the command-parsing states consume rx bytes; anything else is lost.
    assign rx_accept = (state_q == IDLE)    || (state_q == ADDR_LO) ||
                       (state_q == ADDR_HI) || (state_q == COUNT)   ||
                       (state_q == WR_DATA);

    // Outputs are pure decodes of the registered state, so reset forces them
    // to their idle values immediately and nothing half-finished leaks out.
    assign o_debugger_en      = (state_q == WR_MEM) || (state_q == RD_MEM);
    assign o_debugger_rw      = (state_q == WR_MEM) ? RW_WRITE : RW_READ;
    assign o_debugger_address = addr_q;
    assign o_debugger_data    = wdata_q;
    assign o_tx_valid         = (state_q == RD_SEND) || (state_q == RESP);
    assign o_tx_data          = txd_q;
    assign o_busy             = (state_q != IDLE);
    assign o_rx_overrun       = i_rx_valid && !rx_accept;

    // Next-state and datapath update for the command FSM.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        wdata_d = wdata_q;
        txd_d   = txd_q;
        is_rd_d = is_rd_q;
        unique case (state_q)
            IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == OP_READ || i_rx_data == OP_WRITE) begin
                        is_rd_d = (i_rx_data == OP_READ);
                        state_d = ADDR_LO;
                    end else begin
                        txd_d   = ERR_BYTE;
                        state_d = RESP;
                    end
                end
            end
            ADDR_LO: begin
                if (i_rx_valid) begin
                    addr_d[7:0] = i_rx_data;
                    state_d     = ADDR_HI;
                end
            end
            ADDR_HI: begin
                if (i_rx_valid) begin
                    addr_d[15:8] = i_rx_data;
                    state_d      = COUNT;
                end
            end
            COUNT: begin
                if (i_rx_valid) begin
                    count_d = count_load(i_rx_data);
                    state_d = is_rd_q ? RD_MEM : WR_DATA;
                end
            end
            WR_DATA: begin
                if (i_rx_valid) begin
                    wdata_d = i_rx_data;
                    state_d = WR_MEM;
                end
            end
            WR_MEM: begin
                addr_d  = addr_q + 16'd1;
                count_d = count_q - 9'd1;
                if (count_q == 9'd1) begin
                    txd_d   = ACK_BYTE;
                    state_d = RESP;
                end else begin
                    state_d = WR_DATA;
                end
            end
            RD_MEM: begin
                addr_d  = addr_q + 16'd1;
                count_d = count_q - 9'd1;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                // Arbiter returns read data one cycle after the request.
                txd_d   = i_debugger_data;
                state_d = RD_SEND;
            end
            RD_SEND: begin
                if (i_tx_ready) begin
                    state_d = (count_q == 9'd0) ? IDLE : RD_MEM;
                end
            end
            RESP: begin
                if (i_tx_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; async reset aborts any command in flight.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            addr_q  <= 16'h0000;
            count_q <= 9'd0;
            wdata_q <= 8'h00;
            txd_q   <= 8'h00;
            is_rd_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            wdata_q <= wdata_d;
            txd_q   <= txd_d;
            is_rd_q <= is_rd_d;
        end
    end

endmodule

// File: tb/tb_debugger_mem_cmd.sv
// Self-checking bench for debugger_mem_cmd: directed command scenarios plus
// randomized commands checked against a byte-array reference memory and
// expected tx / access queues.
module tb_debugger_mem_cmd;

    typedef logic [24:0] acc_t; // {rw, address, write data (0 for reads)}

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_rx_valid = 1'b0;
    logic [7:0]  i_rx_data = 8'h00;
    logic        o_tx_valid;
    logic [7:0]  o_tx_data;
    logic        i_tx_ready = 1'b1;
    logic        o_debugger_en;
    logic        o_debugger_rw;
    logic [15:0] o_debugger_address;
    logic [7:0]  o_debugger_data;
    logic [7:0]  i_debugger_data;
    logic        o_busy;
    logic        o_rx_overrun;

    int checks = 0;
    int failures = 0;
    int ovr_cnt = 0;
    int rdy_mode = 0; // 0: ready high, 1: ready low, 2: random

    logic [7:0] mem     [65536];
    logic [7:0] ref_mem [65536];
    logic [7:0] rd_q = 8'h00;
    logic [7:0] tx_q[$];
    acc_t       acc_q[$];
    logic [7:0] exp_tx[$];
    acc_t       exp_acc[$];
    logic [7:0] wr_bytes[$];

    debugger_mem_cmd #(.ACK_BYTE(8'hAA), .ERR_BYTE(8'hEE)) dut (
        .i_clk              (i_clk),
        .i_reset_n          (i_reset_n),
        .i_rx_valid         (i_rx_valid),
        .i_rx_data          (i_rx_data),
        .o_tx_valid         (o_tx_valid),
        .o_tx_data          (o_tx_data),
        .i_tx_ready         (i_tx_ready),
        .o_debugger_en      (o_debugger_en),
        .o_debugger_rw      (o_debugger_rw),
        .o_debugger_address (o_debugger_address),
        .o_debugger_data    (o_debugger_data),
        .i_debugger_data    (i_debugger_data),
        .o_busy             (o_busy),
        .o_rx_overrun       (o_rx_overrun)
    );

    always #5 i_clk = ~i_clk;

    // Arbiter model: one-cycle read latency, writes land on the request edge.
    assign i_debugger_data = rd_q;
    always @(posedge i_clk) begin
        if (o_debugger_en) begin
            if (o_debugger_rw) rd_q <= mem[o_debugger_address];
            else mem[o_debugger_address] = o_debugger_data;
        end
    end

    // Observers: accepted tx bytes, issued accesses, overrun pulses.
    always @(posedge i_clk) begin
        if (i_reset_n && o_tx_valid && i_tx_ready) tx_q.push_back(o_tx_data);
        if (i_reset_n && o_debugger_en)
            acc_q.push_back({o_debugger_rw, o_debugger_address, o_debugger_rw ? 8'h00 : o_debugger_data});
        if (i_reset_n && o_rx_overrun) ovr_cnt++;
    end

    // Downstream ready generator.
    always @(negedge i_clk) begin
        case (rdy_mode)
            0:       i_tx_ready = 1'b1;
            1:       i_tx_ready = 1'b0;
            default: i_tx_ready = 1'($urandom % 2);
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        mem[a] = d;
        ref_mem[a] = d;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge i_clk);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output int cyc);
        cyc = 0;
        while (o_busy && cyc < limit) begin
            @(negedge i_clk);
            cyc++;
        end
        chk("idle_after_cmd", {31'd0, o_busy}, 32'd0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_busy",     {31'd0, o_busy},        32'd0);
        chk("rst_tx_valid", {31'd0, o_tx_valid},    32'd0);
        chk("rst_en",       {31'd0, o_debugger_en}, 32'd0);
        chk("rst_overrun",  {31'd0, o_rx_overrun},  32'd0);
        chk("rst_rw",       {31'd0, o_debugger_rw}, 32'd1);
        chk("rst_tx_data",  {24'd0, o_tx_data},     32'd0);
        chk("rst_addr",     {16'd0, o_debugger_address}, 32'd0);
        chk("rst_wdata",    {24'd0, o_debugger_data},    32'd0);
    endtask

    // Issue one command and compare tx bytes and memory accesses with the
    // outcome predicted from the command rules and the reference memory.
    task automatic run_cmd(input logic [7:0] op, input logic [15:0] addr,
                           input logic [7:0] cnt, output int cyc);
        int n;
        int ovr0;
        logic [15:0] a;
        logic [7:0]  d;
        n = (cnt == 8'h00) ? 256 : int'(cnt);
        tx_q.delete(); acc_q.delete(); exp_tx.delete(); exp_acc.delete();
        ovr0 = ovr_cnt;
        while (wr_bytes.size() < n) wr_bytes.push_back(8'($urandom));
        for (int i = 0; i < n && (op == 8'h01 || op == 8'h02); i++) begin
            a = addr + 16'(i);
            if (op == 8'h01) begin
                exp_tx.push_back(ref_mem[a]);
                exp_acc.push_back({1'b1, a, 8'h00});
            end else begin
                ref_mem[a] = wr_bytes[i];
                exp_acc.push_back({1'b0, a, wr_bytes[i]});
            end
        end
        if (op == 8'h02) exp_tx.push_back(8'hAA);
        if (op != 8'h01 && op != 8'h02) exp_tx.push_back(8'hEE);

        send_byte(op);
        if (op == 8'h01 || op == 8'h02) begin
            send_byte(addr[7:0]);
            send_byte(addr[15:8]);
            send_byte(cnt);
            if (op == 8'h02)
                for (int i = 0; i < n; i++) begin
                    d = wr_bytes[i];
                    send_byte(d);
                end
        end
        wr_bytes.delete();
        wait_idle(6000, cyc);

        chk("tx_count", tx_q.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size(); i++)
            chk("tx_byte", (i < tx_q.size()) ? {24'd0, tx_q[i]} : 32'hxxxx_xxxx, {24'd0, exp_tx[i]});
        chk("acc_count", acc_q.size(), exp_acc.size());
        for (int i = 0; i < exp_acc.size(); i++)
            chk("mem_access", (i < acc_q.size()) ? {7'd0, acc_q[i]} : 32'hxxxx_xxxx, {7'd0, exp_acc[i]});
        chk("no_overrun", ovr_cnt, ovr0);
        if (op == 8'h01 || op == 8'h02)
            chk("end_addr", {16'd0, o_debugger_address}, {16'd0, addr + 16'(n)});
    endtask

    initial begin
        int cyc;
        int ovr0;
        int nacc;
        logic [15:0] a;
        logic [7:0]  b;
        logic [7:0]  op;
        logic [7:0]  held;

        for (int i = 0; i < 65536; i++) begin
            b = 8'($urandom);
            mem[i] = b;
            ref_mem[i] = b;
        end

        // Reset state
        repeat (3) @(negedge i_clk);
        chk_reset_vals();
        i_reset_n = 1'b1;
        @(negedge i_clk);

        // Two-byte read
        poke(16'h1234, 8'h5A);
        poke(16'h1235, 8'hA5);
        run_cmd(8'h01, 16'h1234, 8'h02, cyc);

        // Write wrapping through FFFF -> 0000
        wr_bytes.push_back(8'h11);
        wr_bytes.push_back(8'h22);
        run_cmd(8'h02, 16'hFFFF, 8'h02, cyc);
        chk("wrap_mem_ffff", {24'd0, mem[16'hFFFF]}, 32'h11);
        chk("wrap_mem_0000", {24'd0, mem[16'h0000]}, 32'h22);

        // Unknown opcode
        run_cmd(8'h7F, 16'h0000, 8'h00, cyc);

        // Count 0 means 256 bytes; full-rate read is 3 cycles per byte
        run_cmd(8'h01, 16'h0000, 8'h00, cyc);
        chk("rd256_throughput", {31'd0, cyc <= 3 * 256 + 4}, 32'd1);

        // Stall in RD_SEND with a stray rx byte
        a = 16'($urandom);
        tx_q.delete(); acc_q.delete();
        rdy_mode = 1;
        ovr0 = ovr_cnt;
        send_byte(8'h01); send_byte(a[7:0]); send_byte(a[15:8]); send_byte(8'h01);
        cyc = 0;
        while (!o_tx_valid && cyc < 50) begin @(negedge i_clk); cyc++; end
        chk("stall_tx_valid_seen", {31'd0, o_tx_valid}, 32'd1);
        held = ref_mem[a];
        nacc = acc_q.size();
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            if (i == 3) begin i_rx_valid = 1'b1; i_rx_data = 8'h01; end
            if (i == 4) i_rx_valid = 1'b0;
            chk("stall_tx_valid", {31'd0, o_tx_valid}, 32'd1);
            chk("stall_tx_data", {24'd0, o_tx_data}, {24'd0, held});
        end
        chk("stall_overrun_pulses", ovr_cnt - ovr0, 32'd1);
        chk("stall_acc_before", nacc, 32'd1);
        chk("stall_no_extra_acc", acc_q.size(), nacc);
        rdy_mode = 0;
        wait_idle(50, cyc);
        chk("stall_tx_count", tx_q.size(), 32'd1);
        chk("stall_tx_byte", (tx_q.size() > 0) ? {24'd0, tx_q[0]} : 32'hxxxx_xxxx, {24'd0, held});

        // Reset during WR_DATA after 1 of 3 bytes
        a = 16'($urandom_range(0, 16'hFFF0));
        b = 8'($urandom);
        tx_q.delete(); acc_q.delete();
        send_byte(8'h02); send_byte(a[7:0]); send_byte(a[15:8]); send_byte(8'h03);
        send_byte(b);
        @(negedge i_clk);
        i_reset_n = 1'b0;
        #1;
        chk_reset_vals();
        ref_mem[a] = b;
        chk("rst_partial_acc_count", acc_q.size(), 32'd1);
        chk("rst_partial_acc", (acc_q.size() > 0) ? {7'd0, acc_q[0]} : 32'hxxxx_xxxx, {7'd0, 1'b0, a, b});
        repeat (2) @(negedge i_clk);
        chk("rst_no_tx", tx_q.size(), 32'd0);
        i_reset_n = 1'b1;
        run_cmd(8'h01, a, 8'h03, cyc);

        // Randomized commands
        for (int k = 0; k < 24; k++) begin
            case ($urandom % 8)
                0, 1, 2: op = 8'h01;
                3, 4, 5: op = 8'h02;
                default: begin
                    op = 8'($urandom);
                    if (op == 8'h01 || op == 8'h02) op = op + 8'h10;
                end
            endcase
            a = ($urandom % 4 == 0) ? 16'hFFFE : 16'($urandom);
            rdy_mode = ($urandom % 2) ? 0 : 2;
            run_cmd(op, a, 8'($urandom_range(1, 6)), cyc);
        end
        rdy_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
